// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the phase sequencer: state encoding,
// counter widths, and the phase-parameter legality check used at elaboration.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    localparam int INSTR_CNT_W = 32;
    localparam int STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_SAT = 16'hFFFF;

    function automatic bit params_legal(input int n, input int f, input int d, input int w);
        return (n >= 3) && (n <= 16) && (f >= 0) && (f < d) && (d < w) && (w <= n - 1);
    endfunction

endpackage

// File: rtl/phase_strobe_decode.sv
// Combinational decode of registered phase/state into stage strobes, one-hot
// phase and the divided compatibility clock; zero latency, no flow control.
module phase_strobe_decode
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES  = 4,
    parameter int FETCH_PHASE = 0,
    parameter int DMEM_PHASE  = 2,
    parameter int WB_PHASE    = 3,
    parameter int PH_W        = $clog2(NUM_PHASES)
) (
    input  logic [PH_W-1:0]       i_phase,
    input  seq_state_t            i_state,
    output logic [NUM_PHASES-1:0] o_phase_onehot,
    output logic                  o_fetch_en,
    output logic                  o_dmem_en,
    output logic                  o_wb_en,
    output logic                  o_pc_en,
    output logic                  o_slow_clk,
    output logic                  o_stalled,
    output logic                  o_halted
);

    logic w_run;
    logic w_active;

    always_comb begin
        w_run      = (i_state == ST_RUN);
        w_active   = w_run || (i_state == ST_STALL);
        // Strobes fire only in RUN so a frozen STALL phase never repeats one.
        o_fetch_en = w_run && (i_phase == PH_W'(FETCH_PHASE));
        o_dmem_en  = w_run && (i_phase == PH_W'(DMEM_PHASE));
        o_wb_en    = w_run && (i_phase == PH_W'(WB_PHASE));
        o_pc_en    = o_wb_en;
        o_slow_clk = w_active && (i_phase < PH_W'(NUM_PHASES / 2));
        o_stalled  = (i_state == ST_STALL);
        o_halted   = (i_state == ST_HALT);
        for (int i = 0; i < NUM_PHASES; i++) begin
            o_phase_onehot[i] = w_active && (i_phase == PH_W'(i));
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Enable-based multi-phase instruction sequencer with stall, sticky halt and counters.
// One-cycle start latency from run_en; stall_req freezes the phase at the dmem stage.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES  = 4,
    parameter int FETCH_PHASE = 0,
    parameter int DMEM_PHASE  = 2,
    parameter int WB_PHASE    = 3,
    parameter int PH_W        = $clog2(NUM_PHASES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run_en,
    input  logic                   stall_req,
    input  logic                   halt_req,
    output logic [PH_W-1:0]        phase,
    output logic [NUM_PHASES-1:0]  phase_onehot,
    output logic                   fetch_en,
    output logic                   dmem_en,
    output logic                   wb_en,
    output logic                   pc_en,
    output logic                   slow_clk,
    output logic                   stalled,
    output logic                   halted,
    output logic [INSTR_CNT_W-1:0] instr_count,
    output logic [STALL_CNT_W-1:0] stall_count
);

    if (!params_legal(NUM_PHASES, FETCH_PHASE, DMEM_PHASE, WB_PHASE)) begin : g_bad_params
        $error("phase_sequencer: illegal NUM_PHASES/FETCH_PHASE/DMEM_PHASE/WB_PHASE");
    end

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);
    localparam logic [PH_W-1:0] DMEM_PH = PH_W'(DMEM_PHASE);

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic [PH_W-1:0]        r_phase;
    logic [PH_W-1:0]        w_phase_nxt;
    logic                   w_instr_done;
    logic [INSTR_CNT_W-1:0] r_instr_count;
    logic [STALL_CNT_W-1:0] r_stall_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_instr_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run_en) begin
                    w_state_nxt = ST_RUN;
                    w_phase_nxt = '0;
                end
            end
            ST_RUN: begin
                if ((r_phase == DMEM_PH) && stall_req) begin
                    w_state_nxt = ST_STALL;
                end else if (r_phase == LAST_PH) begin
                    w_instr_done = 1'b1;
                    w_phase_nxt  = '0;
                    if (halt_req) begin
                        w_state_nxt = ST_HALT;
                    end
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            ST_STALL: begin
                // Resume past the dmem phase so the access is not repeated.
                if (!stall_req) begin
                    w_state_nxt = ST_RUN;
                    w_phase_nxt = DMEM_PH + PH_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instr_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_instr_done) begin
                r_instr_count <= r_instr_count + INSTR_CNT_W'(1);
            end
            if ((r_state == ST_STALL) && (r_stall_count != STALL_CNT_SAT)) begin
                r_stall_count <= r_stall_count + STALL_CNT_W'(1);
            end
        end
    end

    phase_strobe_decode #(
        .NUM_PHASES  (NUM_PHASES),
        .FETCH_PHASE (FETCH_PHASE),
        .DMEM_PHASE  (DMEM_PHASE),
        .WB_PHASE    (WB_PHASE),
        .PH_W        (PH_W)
    ) u_decode (
        .i_phase        (r_phase),
        .i_state        (r_state),
        .o_phase_onehot (phase_onehot),
        .o_fetch_en     (fetch_en),
        .o_dmem_en      (dmem_en),
        .o_wb_en        (wb_en),
        .o_pc_en        (pc_en),
        .o_slow_clk     (slow_clk),
        .o_stalled      (stalled),
        .o_halted       (halted)
    );

    assign phase       = r_phase;
    assign instr_count = r_instr_count;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed vector table, async reset, random traffic
// against a behavioural model, a 5-phase variant, and stall-counter saturation.
module tb_phase_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic run_en, stall_req, halt_req;

    logic [1:0]  a_phase;
    logic [3:0]  a_onehot;
    logic        a_fetch, a_dmem, a_wb, a_pc, a_slow, a_stalled, a_halted;
    logic [31:0] a_instr;
    logic [15:0] a_stall;

    logic [2:0]  b_phase;
    logic [4:0]  b_onehot;
    logic        b_fetch, b_dmem, b_wb, b_pc, b_slow, b_stalled, b_halted;
    logic [31:0] b_instr;
    logic [15:0] b_stall;

    always #5 clk = ~clk;

    phase_sequencer u_a (
        .clock(clk), .reset(rst_n), .run_en(run_en), .stall_req(stall_req), .halt_req(halt_req),
        .phase(a_phase), .phase_onehot(a_onehot), .fetch_en(a_fetch), .dmem_en(a_dmem),
        .wb_en(a_wb), .pc_en(a_pc), .slow_clk(a_slow), .stalled(a_stalled), .halted(a_halted),
        .instr_count(a_instr), .stall_count(a_stall)
    );

    phase_sequencer #(.NUM_PHASES(5), .FETCH_PHASE(0), .DMEM_PHASE(2), .WB_PHASE(4)) u_b (
        .clock(clk), .reset(rst_n), .run_en(run_en), .stall_req(stall_req), .halt_req(halt_req),
        .phase(b_phase), .phase_onehot(b_onehot), .fetch_en(b_fetch), .dmem_en(b_dmem),
        .wb_en(b_wb), .pc_en(b_pc), .slow_clk(b_slow), .stalled(b_stalled), .halted(b_halted),
        .instr_count(b_instr), .stall_count(b_stall)
    );

    int n_vec = 0;
    int n_bad = 0;
    int sel   = 0;

    // Reference model: sequencer described as flags plus a phase number.
    int     mN = 4, mF = 0, mD = 2, mW = 3;
    bit     m_act, m_stl, m_hlt;
    int     m_phase;
    longint m_instr;
    int     m_stall;

    task automatic model_reset();
        m_act = 0; m_stl = 0; m_hlt = 0; m_phase = 0; m_instr = 0; m_stall = 0;
    endtask

    task automatic model_step(input int r, input int s, input int h);
        if (m_hlt) begin
        end else if (!m_act) begin
            if (r != 0) begin m_act = 1; m_phase = 0; end
        end else if (m_stl) begin
            if (m_stall < 65535) m_stall = m_stall + 1;
            if (s == 0) begin m_stl = 0; m_phase = mD + 1; end
        end else if (m_phase == mD && s != 0) begin
            m_stl = 1;
        end else if (m_phase == mN - 1) begin
            m_instr = (m_instr + 1) % 64'h1_0000_0000;
            m_phase = 0;
            if (h != 0) begin m_hlt = 1; m_act = 0; end
        end else begin
            m_phase = m_phase + 1;
        end
    endtask

    task automatic cmp(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_dut(input string tag);
        longint ph, oh, f, d, w, p, sl, st, hl, ic, sc;
        bit run;
        if (sel == 0) begin
            ph = longint'(a_phase); oh = longint'(a_onehot); f = longint'(a_fetch);
            d = longint'(a_dmem); w = longint'(a_wb); p = longint'(a_pc); sl = longint'(a_slow);
            st = longint'(a_stalled); hl = longint'(a_halted); ic = longint'(a_instr); sc = longint'(a_stall);
        end else begin
            ph = longint'(b_phase); oh = longint'(b_onehot); f = longint'(b_fetch);
            d = longint'(b_dmem); w = longint'(b_wb); p = longint'(b_pc); sl = longint'(b_slow);
            st = longint'(b_stalled); hl = longint'(b_halted); ic = longint'(b_instr); sc = longint'(b_stall);
        end
        run = m_act && !m_stl;
        cmp({tag, " phase"}, ph, longint'(m_phase));
        cmp({tag, " onehot"}, oh, m_act ? (longint'(1) << m_phase) : longint'(0));
        cmp({tag, " fetch_en"}, f, longint'(run && m_phase == mF));
        cmp({tag, " dmem_en"}, d, longint'(run && m_phase == mD));
        cmp({tag, " wb_en"}, w, longint'(run && m_phase == mW));
        cmp({tag, " pc_en"}, p, longint'(run && m_phase == mW));
        cmp({tag, " slow_clk"}, sl, longint'(m_act && m_phase < mN / 2));
        cmp({tag, " stalled"}, st, longint'(m_stl));
        cmp({tag, " halted"}, hl, longint'(m_hlt));
        cmp({tag, " instr_count"}, ic, m_instr);
        cmp({tag, " stall_count"}, sc, longint'(m_stall));
    endtask

    task automatic cycle(input int r, input int s, input int h, input string tag);
        run_en = (r != 0); stall_req = (s != 0); halt_req = (h != 0);
        @(posedge clk);
        model_step(r, s, h);
        #1;
        check_dut(tag);
    endtask

    task automatic do_reset();
        run_en = 0; stall_req = 0; halt_req = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_dut("reset");
        rst_n = 1;
    endtask

    typedef struct {
        int r, s, h;
        int ph, f, d, w, st, hl;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 2, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 3, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 2, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 2, 0, 0, 0, 1, 0};
        tbl[8]  = '{0, 1, 0, 2, 0, 0, 0, 1, 0};
        tbl[9]  = '{0, 1, 0, 2, 0, 0, 0, 1, 0};
        tbl[10] = '{0, 1, 0, 2, 0, 0, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 2, 0, 0, 0, 1, 0};
        tbl[12] = '{0, 0, 0, 3, 0, 0, 1, 0, 0};
        tbl[13] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[15] = '{1, 1, 1, 0, 0, 0, 0, 0, 1};

        // Directed table: start, stall for five cycles, ignored and honoured halt.
        sel = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].r, tbl[i].s, tbl[i].h, $sformatf("tbl%0d", i));
            cmp($sformatf("tbl%0d phase", i), longint'(a_phase), longint'(tbl[i].ph));
            cmp($sformatf("tbl%0d fetch", i), longint'(a_fetch), longint'(tbl[i].f));
            cmp($sformatf("tbl%0d dmem", i), longint'(a_dmem), longint'(tbl[i].d));
            cmp($sformatf("tbl%0d wb", i), longint'(a_wb), longint'(tbl[i].w));
            cmp($sformatf("tbl%0d stalled", i), longint'(a_stalled), longint'(tbl[i].st));
            cmp($sformatf("tbl%0d halted", i), longint'(a_halted), longint'(tbl[i].hl));
        end
        cmp("tbl instr_count", longint'(a_instr), 2);
        cmp("tbl stall_count", longint'(a_stall), 5);

        // Asynchronous reset during phase 2 of the third instruction.
        do_reset();
        cycle(1, 0, 0, "ar_start");
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, "ar_run");
        cmp("ar pre phase", longint'(a_phase), 2);
        cmp("ar pre instr", longint'(a_instr), 2);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_dut("async_reset");
        cmp("ar onehot", longint'(a_onehot), 0);
        @(posedge clk);

        // Random traffic, default phasing.
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                cycle(($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
                      ($urandom_range(0, 15) == 0) ? 1 : 0, "rndA");
            end
        end

        // Five-phase variant: slow_clk high for phases 0-1 only.
        sel = 1; mN = 5; mF = 0; mD = 2; mW = 4;
        do_reset();
        cycle(1, 0, 0, "b_start");
        for (int k = 0; k < 10; k++) begin
            cmp($sformatf("b slow k%0d", k), longint'(b_slow), longint'((k % 5) < 2));
            cmp($sformatf("b phase k%0d", k), longint'(b_phase), longint'(k % 5));
            cycle(0, 0, 0, "b_run");
        end
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
                  ($urandom_range(0, 39) == 0) ? 1 : 0, "rndB");
        end

        // Long stall: counter saturates, then normal resume.
        sel = 0; mN = 4; mF = 0; mD = 2; mW = 3;
        do_reset();
        cycle(1, 0, 0, "sat_start");
        cycle(0, 0, 0, "sat_p1");
        cycle(0, 0, 0, "sat_p2");
        stall_req = 1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            model_step(0, 1, 0);
        end
        #1;
        cmp("sat stall_count", longint'(a_stall), 65535);
        cmp("sat stalled", longint'(a_stalled), 1);
        check_dut("sat_hold");
        cycle(0, 0, 0, "sat_resume");
        cmp("sat resume wb", longint'(a_wb), 1);
        cycle(0, 0, 0, "sat_next");
        cmp("sat next fetch", longint'(a_fetch), 1);
        cmp("sat instr_count", longint'(a_instr), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
